gate_exerciser: RTL

Sequential stimulus and check engine that drives the two inputs of a 2-input logic-gate block under test and checks its output. It walks all four input vectors, holds each for a programmable dwell, samples the gate output at the end of each dwell, and compares it against a golden model. It sits directly upstream of the gate, which is the consumer of `a`/`b` and the producer of `y`, and reports pass/fail to a controller or bench over a start/done handshake.

---
 rtl/gate_pkg.sv | 38 +++
 rtl/gate_ref_model.sv | 16 +
 rtl/gate_exerciser.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate exerciser: op encodings, FSM states and
// the golden gate function.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUFA = 3'd6;
  localparam logic [2:0] OP_BUFB = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Expected gate output for a given op and input pair.
  function automatic logic expected(input logic [2:0] op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_BUFA: r = a;
      OP_BUFB: r = b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden gate used as the reference for the device under test.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  // Evaluate the golden gate for the latched op and current vector.
  always_comb begin
    y_exp = expected(op, a, b);
  end

endmodule

// File: rtl/gate_exerciser.sv
// Walks the four input vectors of a 2-input gate, holds each for DWELL
// cycles, samples the gate output at the end of each dwell and scores it
// against the golden model.
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] op,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  localparam logic [15:0] RELOAD = 16'(DWELL - 1);

  state_t      state;
  logic [15:0] timer;
  logic [1:0]  vec;
  logic [2:0]  op_q;
  logic        y_exp;
  logic        mismatch;

  gate_ref_model u_ref (
    .op    (op_q),
    .a     (vec[1]),
    .b     (vec[0]),
    .y_exp (y_exp)
  );

  // Mismatch of the settled gate output against the reference.
  always_comb begin
    mismatch = (y !== y_exp);
  end

  // Run sequencer: stimulus, dwell timer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      vec        <= '0;
      op_q       <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          a    <= 1'b0;
          b    <= 1'b0;
          if (start && !abort) begin
            state      <= DRIVE;
            op_q       <= op;
            vec        <= '0;
            timer      <= RELOAD;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            a     <= 1'b0;
            b     <= 1'b0;
            busy  <= 1'b0;
            pass  <= 1'b0;
            timer <= '0;
            vec   <= '0;
          end else if (timer == 16'd0) begin
            if (mismatch) begin
              err_count <= err_count + 3'd1;
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_vec   <= vec;
              end
            end
            if (vec != 2'd3) begin
              vec   <= vec + 2'd1;
              {a, b} <= vec + 2'd1;
              timer <= RELOAD;
            end else begin
              // pass must reflect this final sample, so use the pre-update count
              state <= DONE;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 3'd0) && !mismatch;
              vec   <= '0;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          a     <= 1'b0;
          b     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
